// File: rtl/apb_burst_master.sv
// Converts burst commands (FIXED / incrementing) into back-to-back single APB transfers.
// Optional APB_TIMEOUT_EN: a stalled ACCESS phase ends as a slave error after 16 cycles.
module apb_burst_master #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic [ID_WIDTH-1:0]   rid,
  output logic                  rlast,
  output logic                  bresp_valid,
  input  logic                  bresp_ready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [2:0] {IDLE, WAIT_WDATA, SETUP, ACCESS, RD_OUT, WR_RESP} state_t;

  state_t                r_state;
  logic                  r_cmd_ready, r_wdata_ready, r_psel, r_penable, r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rdata;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst, r_rresp, r_bresp;
  logic                  r_err, r_rdata_valid, r_rlast, r_bresp_valid;

  logic                  w_pready, w_pslverr, w_last;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic [ADDR_WIDTH-1:0] w_next_addr;

`ifdef APB_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;
  logic       w_timeout;

  assign w_timeout = (r_state == ACCESS) && !pready && (r_tmo_cnt == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_tmo_cnt <= '0;
    else if (r_state != ACCESS) r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + 4'd1;
  end

  assign w_pready  = pready | w_timeout;
  assign w_pslverr = pslverr | w_timeout;
  assign w_prdata  = w_timeout ? '0 : prdata;
`else
  assign w_pready  = pready;
  assign w_pslverr = pslverr;
  assign w_prdata  = prdata;
`endif

  assign w_last      = (r_beat == r_len);
  // FIXED bursts replay the same address; every other burst type steps by the beat size.
  assign w_next_addr = (r_burst == 2'b00) ? r_addr : r_addr + (ADDR_WIDTH'(1) << r_size);

  // NOTE: every output is a flop updated on the transition into the state that owns it,
  // so all of them read 0 under reset and psel drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_pwdata      <= '0;
      r_rdata       <= '0;
      r_id          <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_rresp       <= '0;
      r_bresp       <= '0;
      r_err         <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rlast       <= 1'b0;
      r_bresp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_write     <= cmd_write;
            r_id        <= cmd_id;
            r_addr      <= cmd_addr;
            r_len       <= cmd_len;
            r_size      <= cmd_size;
            r_burst     <= cmd_burst;
            r_beat      <= '0;
            r_err       <= 1'b0;
            if (cmd_write) begin
              r_wdata_ready <= 1'b1;
              r_state       <= WAIT_WDATA;
            end else begin
              r_psel  <= 1'b1;
              r_state <= SETUP;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        WAIT_WDATA: begin
          if (wdata_valid) begin
            r_pwdata      <= wdata;
            r_wdata_ready <= 1'b0;
            r_psel        <= 1'b1;
            r_state       <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (!r_write) begin
              r_rdata       <= w_prdata;
              r_rresp       <= w_pslverr ? 2'b10 : 2'b00;
              r_rlast       <= w_last;
              r_rdata_valid <= 1'b1;
              r_state       <= RD_OUT;
            end else if (w_last) begin
              r_err         <= r_err | w_pslverr;
              r_bresp       <= (r_err | w_pslverr) ? 2'b10 : 2'b00;
              r_bresp_valid <= 1'b1;
              r_state       <= WR_RESP;
            end else begin
              r_err         <= r_err | w_pslverr;
              r_addr        <= w_next_addr;
              r_beat        <= r_beat + 8'd1;
              r_wdata_ready <= 1'b1;
              r_state       <= WAIT_WDATA;
            end
          end
        end
        RD_OUT: begin
          if (rdata_ready) begin
            r_rdata_valid <= 1'b0;
            if (r_rlast) begin
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_psel  <= 1'b1;
              r_state <= SETUP;
            end
          end
        end
        WR_RESP: begin
          if (bresp_ready) begin
            r_bresp_valid <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign wdata_ready = r_wdata_ready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_write;
  assign paddr       = r_addr;
  assign pwdata      = r_pwdata;
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rresp       = r_rresp;
  assign rid         = r_id;
  assign rlast       = r_rlast;
  assign bresp_valid = r_bresp_valid;
  assign bid         = r_id;
  assign bresp       = r_bresp;

endmodule

// File: tb/tb_apb_burst_master.sv
// Scoreboard bench for apb_burst_master: a burst-level model queues the expected APB
// transfers, read beats and write responses; independent monitors pop and compare them.
module tb_apb_burst_master;

  localparam int IDW = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [IDW-1:0] cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        wdata_valid = 0, wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid, rdata_ready = 0, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [IDW-1:0] rid, bid;
  logic        bresp_valid, bresp_ready = 0;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata = '0;
  logic        pready = 0, pslverr = 0;

  apb_burst_master #(.ID_WIDTH(IDW), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast),
    .bresp_valid(bresp_valid), .bresp_ready(bresp_ready), .bid(bid), .bresp(bresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct { int wait_cyc; bit err; logic [31:0] data; } plan_t;
  typedef struct { logic [31:0] addr; bit write; logic [31:0] data; } apb_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; bit last; logic [IDW-1:0] id; } rd_exp_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;

  plan_t    plan_q[$];
  apb_exp_t apb_q[$];
  rd_exp_t  rd_q[$];
  b_exp_t   b_q[$];

  plan_t       beat_plan[];
  logic [31:0] beat_wdata[];

  int n_vec = 0, n_err = 0;
  int xfer_idx = 0;
  bit hold_req = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Address of beat i: FIXED repeats, anything else strides by 2^size, wrapping at 2^32.
  function automatic logic [31:0] beat_addr(logic [31:0] a, int i, logic [2:0] sz, logic [1:0] b);
    if (b == 2'b00) return a;
    return a + 32'(i) * (32'd1 << sz);
  endfunction

  function automatic void fill_random(int len);
    beat_plan  = new[len + 1];
    beat_wdata = new[len + 1];
    foreach (beat_plan[i]) begin
      beat_plan[i].wait_cyc = $urandom_range(0, 3);
      beat_plan[i].err      = ($urandom_range(0, 5) == 0);
      beat_plan[i].data     = $urandom;
      beat_wdata[i]         = $urandom;
    end
  endfunction

  task automatic issue(input bit wr, input logic [IDW-1:0] id, input logic [31:0] addr,
                       input int len, input logic [2:0] sz, input logic [1:0] bt);
    int  n;
    bit  acc_err;
    bit  tmo;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
    cmd_len = 8'(len); cmd_size = sz; cmd_burst = bt;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      check("cmd_accept_timeout", cmd_ready, 1);
      cmd_valid = 0;
      return;
    end
    acc_err = 0;
    for (int i = 0; i <= len; i++) begin
      apb_exp_t a;
      rd_exp_t  r;
      tmo = TMO && (beat_plan[i].wait_cyc >= 16);
      a.addr = beat_addr(addr, i, sz, bt); a.write = wr; a.data = beat_wdata[i];
      apb_q.push_back(a);
      plan_q.push_back(beat_plan[i]);
      acc_err |= beat_plan[i].err | tmo;
      if (!wr) begin
        r.data = tmo ? 32'd0 : beat_plan[i].data;
        r.resp = (beat_plan[i].err | tmo) ? 2'b10 : 2'b00;
        r.last = (i == len); r.id = id;
        rd_q.push_back(r);
      end
    end
    if (wr) begin
      b_exp_t b;
      b.id = id; b.resp = acc_err ? 2'b10 : 2'b00;
      b_q.push_back(b);
    end
    @(negedge clk);
    cmd_valid = 0; cmd_id = IDW'($urandom); cmd_write = $urandom_range(0, 1);
    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wdata_valid = 1; wdata = beat_wdata[i];
        n = 0;
        while (wdata_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
          check("wdata_accept_timeout", wdata_ready, 1);
          wdata_valid = 0;
          return;
        end
        @(negedge clk);
        wdata_valid = 0;
      end
    end
  endtask

  // APB slave and transfer monitor.
  plan_t       cur;
  int          acc_cnt = 0;
  bit          prev_setup = 0;
  logic [31:0] setup_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      pready = 0; pslverr = 0; prdata = '0; prev_setup = 0; acc_cnt = 0;
    end else begin
      if (prev_setup) check("setup_to_access", {psel, penable}, 2'b11);
      if (psel && !penable) begin
        if (apb_q.size() == 0) check("apb_unexpected", psel, 0);
        else begin
          apb_exp_t e;
          e = apb_q.pop_front();
          check("paddr", paddr, e.addr);
          check("pwrite", pwrite, e.write);
          if (e.write) check("pwdata", pwdata, e.data);
        end
        cur = (plan_q.size() != 0) ? plan_q.pop_front() : '{0, 1'b0, 32'd0};
        setup_addr = paddr; acc_cnt = 0; prev_setup = 1; xfer_idx++;
        pready = 0;
      end else if (psel && penable) begin
        prev_setup = 0;
        check("paddr_stable", paddr, setup_addr);
        acc_cnt++;
        if (acc_cnt > cur.wait_cyc) begin
          pready = 1; pslverr = cur.err; prdata = cur.data;
        end else begin
          pready = 0; pslverr = $urandom_range(0, 1); prdata = $urandom;
        end
      end else begin
`ifdef APB_TIMEOUT_EN
        if (acc_cnt != 0 && cur.wait_cyc >= 16) check("timeout_access_len", acc_cnt, 16);
`endif
        prev_setup = 0; acc_cnt = 0; pready = 0;
      end
    end
  end

  // Read-beat consumer and monitor.
  int          hold_left = 0;
  bit          held = 0;
  logic [38:0] held_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      rdata_ready = 0; held = 0; hold_left = 0;
    end else if (rdata_valid) begin
      check("psel_low_in_rd_out", psel, 0);
      if (held) check("rdata_stable", {rdata, rresp, rlast, rid}, held_val);
      if (hold_req) begin hold_left = 5; hold_req = 0; end
      if (hold_left > 0) begin rdata_ready = 0; hold_left--; end
      else rdata_ready = ($urandom_range(0, 2) != 0);
      if (rdata_ready) begin
        held = 0;
        if (rd_q.size() == 0) check("rd_unexpected", rdata_valid, 0);
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rdata_beat", {rdata, rresp, rlast, rid}, {e.data, e.resp, e.last, e.id});
        end
      end else begin
        held = 1; held_val = {rdata, rresp, rlast, rid};
      end
    end else begin
      rdata_ready = $urandom_range(0, 1); held = 0;
    end
  end

  // Write-response consumer and monitor.
  always @(negedge clk) begin
    if (!rst_n) bresp_ready = 0;
    else begin
      bresp_ready = ($urandom_range(0, 2) != 0);
      if (bresp_valid && bresp_ready) begin
        check("psel_low_in_wr_resp", psel, 0);
        if (b_q.size() == 0) check("b_unexpected", bresp_valid, 0);
        else begin
          b_exp_t e;
          e = b_q.pop_front();
          check("bresp", {bid, bresp}, {e.id, e.resp});
        end
      end
    end
  end

  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          {cmd_ready, wdata_ready, rdata_valid, rdata, rresp, rid, rlast, bresp_valid, bid, bresp,
           psel, penable, pwrite, paddr, pwdata} == '0, 1);
    rst_n = 1;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    fill_random(3);
    foreach (beat_plan[i]) begin beat_plan[i].wait_cyc = 0; beat_plan[i].err = 0; end
    issue(0, 4'h3, 32'h0000_1000, 3, 3'd2, 2'b01);

    fill_random(1);
    beat_plan[0].err = 1; beat_plan[1].err = 0;
    issue(1, 4'h5, 32'h0000_0020, 1, 3'd2, 2'b00);

    fill_random(1);
    issue(0, 4'h9, 32'hFFFF_FFFC, 1, 3'd2, 2'b01);

    hold_req = 1;
    fill_random(1);
    foreach (beat_plan[i]) beat_plan[i].err = 0;
    issue(0, 4'hA, 32'h0000_4000, 1, 3'd2, 2'b01);

    fill_random(0);
    issue(1, 4'hC, 32'h0000_0100, 0, 3'd0, 2'b01);

`ifdef APB_TIMEOUT_EN
    fill_random(0);
    beat_plan[0].wait_cyc = 40;
    issue(0, 4'h6, 32'h0000_0200, 0, 3'd2, 2'b01);
    fill_random(0);
    beat_plan[0].wait_cyc = 40; beat_plan[0].err = 0;
    issue(1, 4'h7, 32'h0000_0300, 0, 3'd2, 2'b01);
`endif

    for (int k = 0; k < 60; k++) begin
      int          len;
      logic [31:0] a;
      len = $urandom_range(0, 5);
      a = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      fill_random(len);
      issue($urandom_range(0, 1), IDW'($urandom), a, len, 3'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)));
    end

    n = 0;
    while ((rd_q.size() + b_q.size() + apb_q.size()) != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain_queues_empty", rd_q.size() + b_q.size() + apb_q.size(), 0);

    // Abort a 4-beat read while beat index 2 is stalled in ACCESS.
    fill_random(3);
    beat_plan[2].wait_cyc = 10;
    base = xfer_idx;
    issue(0, 4'hE, 32'h0000_8000, 3, 3'd2, 2'b01);
    n = 0;
    while (!(xfer_idx == base + 3 && psel && penable) && n < 500) begin @(negedge clk); n++; end
    check("reached_beat2_access", xfer_idx, base + 3);
    #2 rst_n = 0;
    #1;
    check("reset_psel_drop", {psel, penable}, 2'b00);
    check("reset_no_rdata", {rdata_valid, bresp_valid, cmd_ready}, 3'b000);
    rd_q.delete(); apb_q.delete(); plan_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("cmd_ready_after_abort", cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_after_abort", {psel, rdata_valid, bresp_valid}, 3'b000);
    end

    fill_random(2);
    issue(0, 4'h1, 32'h0000_0040, 2, 3'd1, 2'b10);
    n = 0;
    while ((rd_q.size() + b_q.size() + apb_q.size()) != 0 && n < 2000) begin @(negedge clk); n++; end
    check("final_queues_empty", rd_q.size() + b_q.size() + apb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_burst_master.md
APB_BURST_MASTER -- requirements
Module: apb_burst_master

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, transaction ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 SHALL have port cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have ports cmd_id/cmd_addr/cmd_len/cmd_size/cmd_burst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  burst descriptor; beats = cmd_len+1.
REQ-009 SHALL have ports wdata_valid/wdata_ready/wdata  in/out/in  1/1/DATA_WIDTH  write-beat input.
REQ-010 SHALL have ports rdata_valid/rdata_ready/rdata/rresp/rid/rlast  out/in/out/out/out/out  1/1/DATA_WIDTH/2/ID_WIDTH/1  read-beat output.
REQ-011 SHALL have ports bresp_valid/bresp_ready/bid/bresp  out/in/out/out  1/1/ID_WIDTH/2  write response.
REQ-012 SHALL have APB ports psel/penable/pwrite out 1, paddr out ADDR_WIDTH, pwdata out DATA_WIDTH, prdata in DATA_WIDTH, pready/pslverr in 1.

Function
REQ-013 SHALL implement states IDLE, WAIT_WDATA, SETUP, ACCESS, RD_OUT, WR_RESP.
REQ-014 SHALL assert cmd_ready only in IDLE; handshake latches descriptor, clears beat counter and error flag; next state SETUP (read) or WAIT_WDATA (write).
REQ-015 WAIT_WDATA: wdata_ready=1; on wdata_valid latch wdata to pwdata, go SETUP next cycle.
REQ-016 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-017 ACCESS: psel=1, penable=1, paddr/pwrite/pwdata stable; hold until pready=1.
REQ-018 On pready in read: latch prdata, resp=pslverr?2'b10:2'b00, go RD_OUT.
REQ-019 RD_OUT: rdata_valid=1, rid=latched id, rlast=1 iff beat counter==len; on rdata_ready go IDLE if last else advance address and go SETUP.
REQ-020 On pready in write: OR pslverr into sticky error flag; go WR_RESP if last beat else advance address, go WAIT_WDATA.
REQ-021 WR_RESP: bresp_valid=1, bid=latched id, bresp=flag?2'b10:2'b00; on bresp_ready go IDLE.
REQ-022 Address advance: burst 2'b00 (FIXED) unchanged; any other value adds 1<<size, modulo 2^ADDR_WIDTH (wrap-around silent).
REQ-023 psel SHALL be 0 in IDLE, WAIT_WDATA, RD_OUT, WR_RESP; at most one APB transfer in flight.
REQ-024 cmd_len=0 SHALL yield exactly one beat with rlast=1 (read) or one bresp (write).
REQ-025 cmd_valid asserted outside IDLE SHALL be ignored (not accepted, not lost by upstream since cmd_ready=0).

Reset
REQ-026 rst_n low SHALL force IDLE and all outputs 0 (cmd_ready becomes 1 on first cycle after release).
REQ-027 Reset mid-burst SHALL abort: no further APB cycles, no rdata/bresp for the aborted burst.

Configuration
REQ-028 Macro APB_TIMEOUT_EN SHALL, when defined, add a 4-bit counter in ACCESS; 16 cycles without pready terminate the beat as if pready=1, pslverr=1, prdata=0.
REQ-029 Without APB_TIMEOUT_EN ACCESS SHALL wait indefinitely for pready; no counter logic present.

Verification
REQ-030 Read INCR, addr 0x1000, len 3, size 2, pready immediate -> paddr 0x1000/04/08/0C, 4 rdata beats, rlast on 4th, rresp 00.
REQ-031 Write FIXED, addr 0x20, len 1, pslverr=1 on beat 0 only -> paddr 0x20 both beats, single bresp=2'b10.
REQ-032 Read, addr 0xFFFFFFFC, len 1, size 2, INCR -> second paddr 0x00000000.
REQ-033 Read with rdata_ready low 5 cycles -> rdata/rresp held stable, psel=0 throughout, next SETUP after acceptance.
REQ-034 rst_n asserted during ACCESS of beat 2 of 4 -> psel=0 immediately, no rdata_valid, cmd_ready=1 after release.
REQ-035 APB_TIMEOUT_EN defined, pready held 0 -> ACCESS ends after 16 cycles, rresp 2'b10, rdata 0.
